// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Fetch-side program counter and redirect controller for the RV32 pipeline.
// Owns the PC register, drives the instruction-memory fetch handshake, turns
// the EX-stage taken decision (pcsel) into IF/ID + ID/EX squashes and a PC
// load, and raises a one-cycle trap pulse when the redirect target is not
// word aligned. After every accepted redirect, pcsel is ignored for SHADOW
// cycles because it comes from instructions that are being squashed.
//
// Ports
//   i_clock         sole clock, rising edge
//   i_resetn        synchronous active-low reset
//   i_pcsel         EX-stage taken branch/jump
//   i_alu_target    EX-stage target address
//   i_stall         hazard stall: hold PC, no fetch advance
//   i_imem_ready    instruction memory accepts the current request
//   o_fetch_req     fetch request valid
//   o_pc            current fetch address
//   o_pc_plus4      o_pc + 4 (mod 2^32)
//   o_flush_if_id   squash IF/ID register
//   o_flush_id_ex   squash ID/EX register
//   o_misalign      one-cycle misaligned-target trap pulse
//   o_mtval         offending target, valid while o_misalign = 1
//   o_redirect_cnt  accepted redirects, wrapping
// ---------------------------------------------------------------------------
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0010,
    parameter int unsigned SHADOW   = 2
) (
    input  logic        i_clock,
    input  logic        i_resetn,
    input  logic        i_pcsel,
    input  logic [31:0] i_alu_target,
    input  logic        i_stall,
    input  logic        i_imem_ready,
    output logic        o_fetch_req,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_flush_if_id,
    output logic        o_flush_id_ex,
    output logic        o_misalign,
    output logic [31:0] o_mtval,
    output logic [31:0] o_redirect_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SHADOW = 2'd2
    } state_t;

    localparam logic [2:0] SHADOW_INIT = 3'(SHADOW);

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;
    logic [2:0]  r_shadow_cnt;
    logic [31:0] r_redirect_cnt;
    logic        r_misalign;
    logic [31:0] r_mtval;

    logic        w_redirect;
    logic        w_advance;
    logic [31:0] w_target;

    // Bit 0 is always dropped (jalr rule); bit 1 decides alignment.
    assign w_target = {i_alu_target[31:1], 1'b0};

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT:   w_state_next = ST_RUN;
            ST_RUN:    w_state_next = i_pcsel ? ST_SHADOW : ST_RUN;
            // Leave on the edge where the counter reads 1, so the window
            // covers exactly SHADOW cycles.
            ST_SHADOW: w_state_next = (r_shadow_cnt == 3'd1) ? ST_RUN : ST_SHADOW;
            default:   w_state_next = ST_BOOT;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / control decode
    // -----------------------------------------------------------------------
    always_comb begin
        w_redirect    = 1'b0;
        w_advance     = 1'b0;
        o_fetch_req   = 1'b0;
        case (r_state)
            ST_RUN: begin
                o_fetch_req = 1'b1;
                w_redirect  = i_pcsel;
                w_advance   = !i_stall && i_imem_ready;
            end
            ST_SHADOW: begin
                o_fetch_req = 1'b1;
                w_advance   = !i_stall && i_imem_ready;
            end
            default: begin
                o_fetch_req = 1'b0;
            end
        endcase
        o_flush_if_id = w_redirect;
        o_flush_id_ex = w_redirect;
    end

    // -----------------------------------------------------------------------
    // Datapath: PC, shadow counter, redirect counter, trap capture
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_pc           <= RESET_PC;
            r_shadow_cnt   <= 3'd0;
            r_redirect_cnt <= 32'd0;
            r_misalign     <= 1'b0;
            r_mtval        <= 32'd0;
        end else begin
            r_misalign <= 1'b0;
            if (w_redirect) begin
                // A redirect beats stall and any pending unaccepted fetch.
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
                r_shadow_cnt   <= SHADOW_INIT;
                if (w_target[1]) begin
                    r_pc       <= TRAP_VEC;
                    r_misalign <= 1'b1;
                    r_mtval    <= w_target;
                end else begin
                    r_pc <= w_target;
                end
            end else begin
                // Counter runs through stalled cycles as well.
                if (r_state == ST_SHADOW) begin
                    r_shadow_cnt <= r_shadow_cnt - 3'd1;
                end
                if (w_advance) begin
                    r_pc <= r_pc + 32'd4;
                end
            end
        end
    end

    assign o_pc           = r_pc;
    assign o_pc_plus4     = r_pc + 32'd4;
    assign o_misalign     = r_misalign;
    assign o_mtval        = r_mtval;
    assign o_redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_ctrl
//
// Directed walk through the main fetch/redirect scenarios, followed by a
// randomized run. A cycle-level reference model (fetch phase flag, cycle
// index of the last accepted redirect, plain PC arithmetic) predicts every
// output each cycle.
// ---------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0010;
    localparam int          SHADOW   = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pcsel;
    logic [31:0] alu_target;
    logic        stall;
    logic        imem_ready;
    logic        fetch_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        misalign;
    logic [31:0] mtval;
    logic [31:0] redirect_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_booting;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_mis;
    logic [31:0] m_mtval;
    int          m_cyc;
    int          m_last_redirect;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(
        .RESET_PC (RESET_PC),
        .TRAP_VEC (TRAP_VEC),
        .SHADOW   (SHADOW)
    ) dut (
        .i_clock        (clk),
        .i_resetn       (resetn),
        .i_pcsel        (pcsel),
        .i_alu_target   (alu_target),
        .i_stall        (stall),
        .i_imem_ready   (imem_ready),
        .o_fetch_req    (fetch_req),
        .o_pc           (pc),
        .o_pc_plus4     (pc_plus4),
        .o_flush_if_id  (flush_if_id),
        .o_flush_id_ex  (flush_id_ex),
        .o_misalign     (misalign),
        .o_mtval        (mtval),
        .o_redirect_cnt (redirect_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc %0d got %h expected %h", tag, m_cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_booting       = 1'b1;
        m_pc            = RESET_PC;
        m_cnt           = 32'd0;
        m_mis           = 1'b0;
        m_mtval         = 32'd0;
        m_last_redirect = -100;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare all
    // outputs against the model, then advance the model past the next rising
    // edge.
    task automatic step(input bit rn, input bit sel, input logic [31:0] tgt,
                        input bit stl, input bit rdy);
        bit          honour;
        logic [31:0] t;
        @(negedge clk);
        resetn     = rn;
        pcsel      = sel;
        alu_target = tgt;
        stall      = stl;
        imem_ready = rdy;
        #1;
        honour = !m_booting && (m_cyc > m_last_redirect + SHADOW);
        check("fetch_req",   {31'd0, fetch_req},   {31'd0, !m_booting});
        check("pc",          pc,                   m_pc);
        check("pc_plus4",    pc_plus4,             m_pc + 32'd4);
        check("flush_if_id", {31'd0, flush_if_id}, {31'd0, honour && sel});
        check("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, honour && sel});
        check("misalign",    {31'd0, misalign},    {31'd0, m_mis});
        if (m_mis) check("mtval", mtval, m_mtval);
        check("redirect_cnt", redirect_cnt, m_cnt);
        $display("cyc %0d rstn %b sel %b tgt %h stall %b rdy %b | req %b pc %h fl %b mis %b cnt %0d",
                 m_cyc, rn, sel, tgt, stl, rdy, fetch_req, pc, flush_if_id, misalign, redirect_cnt);

        // Model update for the coming edge
        if (!rn) begin
            model_reset();
        end else if (m_booting) begin
            m_booting = 1'b0;
            m_mis     = 1'b0;
        end else if (honour && sel) begin
            t     = tgt & ~32'd1;
            m_cnt = m_cnt + 32'd1;
            m_last_redirect = m_cyc;
            if (t % 4 != 0) begin
                m_pc    = TRAP_VEC;
                m_mis   = 1'b1;
                m_mtval = t;
            end else begin
                m_pc  = t;
                m_mis = 1'b0;
            end
        end else begin
            m_mis = 1'b0;
            if (!stl && rdy) m_pc = m_pc + 32'd4;
        end
        m_cyc++;
    endtask

    initial begin
        resetn     = 1'b0;
        pcsel      = 1'b0;
        alu_target = 32'd0;
        stall      = 1'b0;
        imem_ready = 1'b1;
        m_cyc      = 0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state, BOOT cycle, then sequential fetch 0,4,8
        step(1, 0, 0, 0, 1);
        check("boot_pc", pc, 32'd0);
        check("boot_req", {31'd0, fetch_req}, 32'd0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // pc = 8, memory not ready for three cycles
        step(1, 0, 0, 0, 0);
        check("hold_pc8", pc, 32'd8);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("adv_pc12", pc, 32'd12);
        step(1, 0, 0, 0, 1);
        // pc = 20: aligned redirect, pcsel held through the shadow window
        step(1, 1, 32'h0000_0101, 0, 1);
        check("redir_flush", {31'd0, flush_if_id}, 32'd1);
        step(1, 1, 32'h0000_0101, 0, 1);
        check("redir_pc", pc, 32'h100);
        check("redir_cnt", redirect_cnt, 32'd1);
        step(1, 1, 32'h0000_0101, 0, 1);
        check("shadow_noflush", {31'd0, flush_id_ex}, 32'd0);
        step(1, 0, 0, 0, 1);
        check("shadow_pc108", pc, 32'h108);
        // Misaligned target
        step(1, 1, 32'h0000_0202, 0, 1);
        step(1, 0, 0, 0, 1);
        check("trap_pc", pc, TRAP_VEC);
        check("trap_mtval", mtval, 32'h202);
        step(1, 0, 0, 0, 1);
        check("trap_pulse_end", {31'd0, misalign}, 32'd0);
        // Redirect beats stall
        step(1, 1, 32'h0000_0400, 1, 1);
        step(1, 0, 0, 1, 1);
        check("stall_redir_pc", pc, 32'h400);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        // Redirect to 0x800, then reset in the first shadow cycle
        step(1, 1, 32'h0000_0800, 0, 1);
        step(0, 1, 32'h0000_0123, 1, 1);
        step(1, 0, 0, 0, 1);
        check("rst_pc", pc, 32'd0);
        check("rst_cnt", redirect_cnt, 32'd0);
        step(1, 0, 0, 0, 1);
        // PC wrap at 2^32
        step(1, 1, 32'hFFFF_FFFD, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        check("wrap_pc", pc, 32'd0);

        // Randomized run
        for (int i = 0; i < 1500; i++) begin
            bit          rn, sel, stl, rdy;
            logic [31:0] tgt;
            rn  = ($urandom_range(63) != 0);
            sel = ($urandom_range(3) == 0);
            stl = ($urandom_range(3) == 0);
            rdy = ($urandom_range(3) != 0);
            tgt = $urandom;
            if ($urandom_range(7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            step(rn, sel, tgt, stl, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Fetch-side program-counter and redirect controller for the RV32 pipeline. It consumes the EX-stage taken-branch/jump decision (`pcsel`) and its target. It owns the PC register and drives the instruction-memory fetch handshake. It also generates the IF/ID and ID/EX squash signals and the one-cycle misaligned-target trap. A post-redirect shadow window ignores `pcsel` from squashed slots, and a wrapping counter records accepted redirects.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- TRAP_VEC, 32'h0000_0010, PC loaded on misaligned redirect target
- SHADOW, 2, cycles after a redirect during which `pcsel` is ignored (1..7)

Ports:
- clock  in  1  sole clock, rising edge
- resetn  in  1  reset, synchronous, active-low
- pcsel  in  1  EX-stage taken branch/jump
- alu_target  in  32  EX-stage target address (branch, jal, jalr)
- stall  in  1  hazard stall: hold PC, no fetch advance
- imem_ready  in  1  instruction memory accepts current request
- fetch_req  out  1  fetch request valid
- pc  out  32  current fetch address
- pc_plus4  out  32  pc + 4, modulo 2^32
- flush_if_id  out  1  squash IF/ID register
- flush_id_ex  out  1  squash ID/EX register
- misalign  out  1  one-cycle trap pulse
- mtval  out  32  offending target, valid while `misalign` = 1
- redirect_cnt  out  32  accepted redirects, wraps

## Operation
- States: BOOT, RUN, SHADOW.
- Reset (resetn = 0 at an edge) forces:
  - state = BOOT, pc = RESET_PC, shadow counter = 0, redirect_cnt = 0
  - misalign = 0, mtval = 0
  - Overrides every other input.
- BOOT:
  - fetch_req = 0, flushes = 0, inputs ignored.
  - Next edge enters RUN; pc is unchanged.
- RUN:
  - fetch_req = 1.
  - A redirect is accepted when `pcsel` = 1 (combinational): flush_if_id = flush_id_ex = 1 in that cycle.
  - Redirect target t = {alu_target[31:1], 1'b0}; bit 0 is always cleared (jalr rule).
  - If t[1] = 0: pc <= t.
  - If t[1] = 1: pc <= TRAP_VEC, misalign <= 1 for exactly one cycle, mtval <= t.
  - On any accepted redirect: redirect_cnt <= redirect_cnt + 1 and state <= SHADOW with counter = SHADOW.
  - Otherwise, if stall = 0 and imem_ready = 1: pc <= pc + 4 (wraps at 2^32).
  - Otherwise pc holds; a pending request keeps the same address.
- SHADOW:
  - pcsel is ignored: no flush, no count, no pc load from alu_target.
  - fetch_req = 1; pc advances on (!stall && imem_ready) exactly as in RUN.
  - The counter decrements every cycle, including stalled cycles; it returns to RUN on the edge where it is 1.
- Priority within a cycle: resetn > accepted pcsel > stall > imem_ready.
  - A redirect overrides stall; the stalled fetch is cancelled.
  - A redirect overrides a pending unaccepted fetch, so the address may change without a handshake only on a redirect.
- pc_plus4 is always pc + 4 (combinational).

## Timing
- Redirect latency: pcsel sampled at edge N, so fetch_req carries the target from cycle N+1. Flushes are combinational in cycle N only.
- misalign and mtval are registered: asserted in cycle N+1 and cleared at the next edge.
- Shadow window is SHADOW cycles (N+1 .. N+SHADOW); pcsel is honoured again from cycle N+SHADOW+1.
- Sequential fetch: one address per cycle when imem_ready stays high; no bubbles.
- BOOT lasts exactly one cycle after reset deassertion; the first fetch at RESET_PC is presented in the cycle after BOOT.
- Reset mid-SHADOW or mid-stall aborts everything on the same edge: pc = RESET_PC, redirect_cnt = 0.
- redirect_cnt wraps 32'hFFFF_FFFF -> 0 with no flag.

## Test plan
- Reset then free-run, imem_ready = 1: pc = 0 during BOOT, fetch_req = 0; then 0, 4, 8, 12 on consecutive cycles.
- imem_ready low for 3 cycles at pc = 8: pc holds 8 and fetch_req stays 1; advances to 12 on the first ready cycle.
- pcsel = 1 with alu_target = 32'h0000_0101 at pc = 20: flush_if_id = flush_id_ex = 1 that cycle; pc = 32'h100 next; redirect_cnt = 1; pcsel held high for the next 2 cycles gives no flush and no count; pc = 0x104, 0x108.
- pcsel = 1 with alu_target = 32'h0000_0202: pc = TRAP_VEC (0x10), misalign = 1 for one cycle, mtval = 32'h202.
- stall = 1 and pcsel = 1 in the same cycle, target 0x400: redirect wins; pc = 0x400, flushes asserted.
- resetn = 0 in the first SHADOW cycle after a redirect to 0x800: next cycle pc = 0, state BOOT, redirect_cnt = 0, misalign = 0.
